// File: rtl/pattern_sequencer.sv
// LED pattern sequencer: plays up to DEPTH stored 3-bit patterns, each held for a
// programmable number of prescaler ticks and followed by a one-tick blank gap.
module pattern_sequencer #(
  parameter int unsigned N     = 20,
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] len,
  input  logic [3:0] hold,
  input  logic       load_we,
  input  logic [2:0] load_addr,
  input  logic [2:0] load_data,
  output logic [2:0] data,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  typedef enum logic [1:0] {StIdle, StShow, StGap, StDone} state_e;

  state_e       state_q;
  logic [N-1:0] tick_cnt_q;
  logic [3:0]   hold_cnt_q;
  logic [3:0]   len_q;
  logic [3:0]   hold_q;
  // Eight physical slots; slots at or above DEPTH are never written so read as 0.
  logic [2:0]   mem_q [8];

  logic       tick;
  logic       wr_ok;
  logic [3:0] len_eff;
  logic [3:0] hold_eff;
  logic [2:0] step_nxt;
  logic       abortable;

  assign tick      = &tick_cnt_q;
  assign wr_ok     = load_we && (state_q == StIdle) && (32'(load_addr) < DEPTH);
  assign len_eff   = (32'(len) > DEPTH) ? 4'(DEPTH) : len;
  assign hold_eff  = (hold == 4'd0) ? 4'd1 : hold;
  assign step_nxt  = step + 3'd1;
  assign abortable = (state_q == StShow) || (state_q == StGap);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      data       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step       <= '0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_q + N'(1);
      done       <= 1'b0;
      if (wr_ok) begin
        mem_q[load_addr] <= load_data;
      end
      if (abort && abortable) begin
        state_q    <= StIdle;
        data       <= '0;
        busy       <= 1'b0;
        step       <= '0;
        hold_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            data <= '0;
            busy <= 1'b0;
            if (start) begin
              tick_cnt_q <= '0;
              hold_cnt_q <= '0;
              step       <= '0;
              len_q      <= len_eff;
              hold_q     <= hold_eff;
              if (len_eff != 4'd0) begin
                state_q <= StShow;
                busy    <= 1'b1;
                // Same-cycle write to slot 0 must be visible on the first pattern.
                data    <= (wr_ok && (load_addr == 3'd0)) ? load_data : mem_q[0];
              end else begin
                state_q <= StDone;
                done    <= 1'b1;
              end
            end
          end
          StShow: begin
            if (tick) begin
              if (hold_cnt_q == hold_q - 4'd1) begin
                data       <= '0;
                hold_cnt_q <= '0;
                state_q    <= StGap;
              end else begin
                hold_cnt_q <= hold_cnt_q + 4'd1;
              end
            end
          end
          StGap: begin
            if (tick) begin
              if ({1'b0, step} == len_q - 4'd1) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                step    <= step_nxt;
                data    <= mem_q[step_nxt];
                state_q <= StShow;
              end
            end
          end
          StDone: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with N=2 (tick every 4 clocks), DEPTH=8.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] len;
  logic [3:0] hold;
  logic       load_we;
  logic [2:0] load_addr;
  logic [2:0] load_data;
  logic [2:0] data;
  logic       busy;
  logic       done;
  logic [2:0] step;

  int vectors    = 0;
  int miscompares = 0;

  logic [2:0] pat [8] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7, 3'd3};

  pattern_sequencer #(
    .N     (2),
    .DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .len       (len),
    .hold      (hold),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] d, input logic b, input logic dn);
    chk({tag, ".data"}, 8'(data), 8'(d));
    chk({tag, ".busy"}, 8'(busy), 8'(b));
    chk({tag, ".done"}, 8'(done), 8'(dn));
  endtask

  initial begin
    logic [2:0] d;
    logic       seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; hold = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    cyc();
    cyc();
    chk_out("reset", 3'd0, 1'b0, 1'b0);
    chk("reset.step", 8'(step), 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_we = 1'b1; load_addr = 3'(i); load_data = pat[i];
      cyc();
    end
    load_we = 1'b0;

    // len=3 hold=2: 8 cycles shown, 4 cycles gap per step, done 36 cycles after accept
    len = 4'd3; hold = 4'd2; start = 1'b1;
    for (int i = 0; i < 38; i++) begin
      cyc();
      start = 1'b0;
      if (i < 36) begin
        d = ((i % 12) < 8) ? pat[i / 12] : 3'd0;
        chk_out($sformatf("play3[%0d]", i), d, 1'b1, 1'b0);
        chk($sformatf("play3[%0d].step", i), 8'(step), 8'(i / 12));
      end else begin
        chk_out($sformatf("play3[%0d]", i), 3'd0, 1'b0, (i == 36));
      end
    end

    // len=0: immediate done pulse, busy never rises
    len = 4'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("len0[0]", 3'd0, 1'b0, 1'b1);
    cyc();
    chk_out("len0[1]", 3'd0, 1'b0, 1'b0);

    // len=15 clamps to 8, hold=0 clamps to 1; start+load mid-playback must be ignored
    len = 4'd15; hold = 4'd0; start = 1'b1;
    for (int i = 0; i < 66; i++) begin
      cyc();
      start = 1'b0; load_we = 1'b0;
      if (i < 64) begin
        d = ((i % 8) < 4) ? pat[i / 8] : 3'd0;
        chk_out($sformatf("play8[%0d]", i), d, 1'b1, 1'b0);
        chk($sformatf("play8[%0d].step", i), 8'(step), 8'(i / 8));
      end else begin
        chk_out($sformatf("play8[%0d]", i), 3'd0, 1'b0, (i == 64));
      end
      if (i == 10) begin
        start = 1'b1; load_we = 1'b1; load_addr = 3'd0; load_data = 3'd7;
      end
    end

    // Abort on a tick edge during SHOW of step 1; abort wins over the tick
    len = 4'd3; hold = 4'd2; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      start = 1'b0;
      d = ((i % 12) < 8) ? pat[i / 12] : 3'd0;
      chk_out($sformatf("abort_run[%0d]", i), d, 1'b1, 1'b0);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_out("abort", 3'd0, 1'b0, 1'b0);
    chk("abort.step", 8'(step), 8'd0);
    seen = 1'b0;
    repeat (40) begin
      cyc();
      seen = seen | done | busy;
    end
    chk("abort.no_done", 8'(seen), 8'd0);

    // Replay from step 0 with the original slot 0 value, then reset mid-GAP
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("replay[0]", pat[0], 1'b1, 1'b0);
    chk("replay[0].step", 8'(step), 8'd0);
    repeat (9) cyc();
    chk_out("replay_gap", 3'd0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_out("rst_gap", 3'd0, 1'b0, 1'b0);
    chk("rst_gap.step", 8'(step), 8'd0);

    // Memory was cleared: len=1 plays a blank pattern, done after 12 cycles
    len = 4'd1; hold = 4'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("cleared[0]", 3'd0, 1'b1, 1'b0);
    repeat (11) cyc();
    chk_out("cleared[11]", 3'd0, 1'b1, 1'b0);
    cyc();
    chk_out("cleared[12]", 3'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
